// File: rtl/rv32i_types.sv
// Shared RV32I types: opcode enum, fetch FSM states and the fetch packet.
`default_nettype none

package rv32i_types;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_skid_buffer.sv
// One-entry holding buffer for a fetched pc/instruction pair; flush wins over load.
`default_nettype none

module if_skid_buffer
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic       unload_i,
  input  fetch_pkt_t data_i,
  output fetch_pkt_t data_o,
  output logic       valid_o
);

  logic       valid_q;
  fetch_pkt_t data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, buffers one instruction under
// decode stall, and flushes on execute-stage redirects.
`default_nettype none

module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output rv32i_opcode if_id_opcode,
  output logic [2:0]  if_id_funct3,
  output logic [6:0]  if_id_funct7
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drop_pc_q, drop_pc_d;
  fetch_pkt_t   if_id_q, if_id_d;
  logic         valid_q, valid_d;

  logic       accepting;
  logic       fetch_resp;
  logic       buf_load, buf_unload, buf_flush, buf_valid;
  fetch_pkt_t buf_data;

  assign accepting  = !valid_q || !stall;
  assign fetch_resp = (state_q == FETCH) && imem_resp;

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (buf_flush),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .data_i   ('{pc: fetch_pc_q, instr: imem_rdata}),
    .data_o   (buf_data),
    .valid_o  (buf_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect)                     state_d = imem_resp ? FETCH : DROP;
        else if (imem_resp && !accepting) state_d = HOLD;
      end
      HOLD:    if (redirect || !stall) state_d = FETCH;
      DROP:    if (imem_resp)          state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // While a redirected request is still outstanding the old address must stay on the bus.
  always_comb begin
    imem_read    = !rst && (state_q != HOLD);
    imem_address = (state_q == DROP) ? drop_pc_q : fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_pc_d  = drop_pc_q;
    if_id_d    = if_id_q;
    valid_d    = valid_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_flush  = 1'b0;
    if (redirect) begin
      valid_d    = 1'b0;
      buf_flush  = 1'b1;
      fetch_pc_d = align_pc(redirect_pc);
      if ((state_q == FETCH) && !imem_resp) drop_pc_d = fetch_pc_q;
    end else begin
      if (fetch_resp) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (fetch_resp && accepting) begin
        if_id_d = '{pc: fetch_pc_q, instr: imem_rdata};
        valid_d = 1'b1;
      end else if (fetch_resp) begin
        buf_load = 1'b1;
      end else if (buf_valid && !stall) begin
        if_id_d    = buf_data;
        valid_d    = 1'b1;
        buf_unload = 1'b1;
      end else if (valid_q && !stall) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_pc_q  <= '0;
      if_id_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      if_id_q    <= if_id_d;
      valid_q    <= valid_d;
    end
  end

  assign if_id_valid  = valid_q;
  assign if_id_pc     = if_id_q.pc;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_opcode = rv32i_opcode'(if_id_q.instr[6:0]);
  assign if_id_funct3 = if_id_q.instr[14:12];
  assign if_id_funct7 = if_id_q.instr[31:25];

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
`default_nettype none

module tb_if_stage;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  rv32i_opcode if_id_opcode;
  logic [2:0]  if_id_funct3;
  logic [6:0]  if_id_funct7;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] RPC = 32'h4000_0000;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_opcode (if_id_opcode),
    .if_id_funct3 (if_id_funct3),
    .if_id_funct7 (if_id_funct7)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_resp = 1'b0; imem_rdata = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic respond(input logic [31:0] data);
    imem_resp = 1'b1; imem_rdata = data;
    tick();
    imem_resp = 1'b0; imem_rdata = '0;
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_resp = 1'b0; imem_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_read, if_id_valid, if_id_pc, if_id_instr} !== 66'd0) begin
      errors++; $display("FAIL reset_outputs: got read=%b valid=%b pc=%h instr=%h, want all 0", imem_read, if_id_valid, if_id_pc, if_id_instr);
    end
    checks++;
    if ({if_id_opcode, if_id_funct3, if_id_funct7} !== 17'd0) begin
      errors++; $display("FAIL reset_fields: got op=%h f3=%h f7=%h, want 0", if_id_opcode, if_id_funct3, if_id_funct7);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_read, imem_address} !== {1'b1, RPC}) begin
      errors++; $display("FAIL reset_release: got read=%b addr=%h, want 1 %h", imem_read, imem_address, RPC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h0000_0013; words[1] = 32'h40B5_0533; words[2] = 32'h0040_A103;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_read, imem_address} !== {1'b1, RPC + 32'(4 * i)}) begin
        errors++; $display("FAIL seq_addr%0d: got read=%b addr=%h, want 1 %h", i, imem_read, imem_address, RPC + 32'(4 * i));
      end
      tick();
      checks++;
      if ({if_id_valid, imem_address} !== {1'b0, RPC + 32'(4 * i)}) begin
        errors++; $display("FAIL seq_wait%0d: got valid=%b addr=%h, want 0 %h", i, if_id_valid, imem_address, RPC + 32'(4 * i));
      end
      respond(words[i]);
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, RPC + 32'(4 * i), words[i]}) begin
        errors++; $display("FAIL seq_out%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", i, if_id_valid, if_id_pc, if_id_instr, RPC + 32'(4 * i), words[i]);
      end
    end
    checks++;
    if ({if_id_opcode, if_id_funct3, if_id_funct7} !== {OP_LOAD, 3'd2, 7'd0}) begin
      errors++; $display("FAIL seq_fields: got op=%h f3=%h f7=%h, want 03 2 00", if_id_opcode, if_id_funct3, if_id_funct7);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    respond(32'h0000_0093);
    stall = 1'b1;
    tick();
    checks++;
    if ({imem_read, imem_address, if_id_valid, if_id_pc} !== {1'b1, RPC + 32'd4, 1'b1, RPC}) begin
      errors++; $display("FAIL stall_wait: got read=%b addr=%h valid=%b pc=%h", imem_read, imem_address, if_id_valid, if_id_pc);
    end
    respond(32'h0000_0013);
    checks++;
    if ({imem_read, if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 1'b1, RPC, 32'h0000_0093}) begin
      errors++; $display("FAIL stall_hold: got read=%b valid=%b pc=%h instr=%h, want 0 1 %h 00000093", imem_read, if_id_valid, if_id_pc, if_id_instr, RPC);
    end
    tick();
    checks++;
    if ({imem_read, if_id_pc} !== {1'b0, RPC}) begin
      errors++; $display("FAIL stall_hold2: got read=%b pc=%h, want 0 %h", imem_read, if_id_pc, RPC);
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr, imem_read, imem_address} !== {1'b1, RPC + 32'd4, 32'h0000_0013, 1'b1, RPC + 32'd8}) begin
      errors++; $display("FAIL stall_release: got valid=%b pc=%h instr=%h read=%b addr=%h", if_id_valid, if_id_pc, if_id_instr, imem_read, imem_address);
    end
    checks++;
    if (if_id_opcode !== OP_IMM) begin
      errors++; $display("FAIL stall_opcode: got %h, want 13", if_id_opcode);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++; $display("FAIL stall_consume: got valid=%b, want 0", if_id_valid);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    respond(32'h0000_0113);
    stall = 1'b1;
    respond(32'h0000_0193);
    redirect = 1'b1; redirect_pc = 32'h4000_0300;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++;
    if ({if_id_valid, imem_read, imem_address} !== {1'b0, 1'b1, 32'h4000_0300}) begin
      errors++; $display("FAIL redir_hold: got valid=%b read=%b addr=%h, want 0 1 40000300", if_id_valid, imem_read, imem_address);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_hold_buf: got valid=%b, want 0", if_id_valid);
    end
    respond(32'h0000_0213);
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h4000_0300, 32'h0000_0213}) begin
      errors++; $display("FAIL redir_hold_next: got valid=%b pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h4000_0100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_read, imem_address, if_id_valid} !== {1'b1, RPC, 1'b0}) begin
        errors++; $display("FAIL drop_hold%0d: got read=%b addr=%h valid=%b, want 1 %h 0", i, imem_read, imem_address, if_id_valid, RPC);
      end
      if (i < 2) tick();
    end
    respond(32'hDEAD_BEEF);
    checks++;
    if ({imem_read, imem_address, if_id_valid} !== {1'b1, 32'h4000_0100, 1'b0}) begin
      errors++; $display("FAIL drop_done: got read=%b addr=%h valid=%b, want 1 40000100 0", imem_read, imem_address, if_id_valid);
    end
    respond(32'h0000_0033);
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h4000_0100, 32'h0000_0033}) begin
      errors++; $display("FAIL drop_next: got valid=%b pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_redirect_in_drop();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h4000_0100;
    tick();
    redirect_pc = 32'h4000_0200;
    tick();
    redirect = 1'b0;
    checks++;
    if ({imem_read, imem_address} !== {1'b1, RPC}) begin
      errors++; $display("FAIL drop_retarget_hold: got read=%b addr=%h, want 1 %h", imem_read, imem_address, RPC);
    end
    respond(32'hDEAD_BEEF);
    checks++;
    if ({imem_address, if_id_valid} !== {32'h4000_0200, 1'b0}) begin
      errors++; $display("FAIL drop_retarget: got addr=%h valid=%b, want 40000200 0", imem_address, if_id_valid);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    respond(32'h0000_0013);
    redirect = 1'b1; redirect_pc = 32'h4000_0200;
    respond(32'h0BAD_0BAD);
    redirect = 1'b0;
    checks++;
    if ({if_id_valid, imem_read, imem_address} !== {1'b0, 1'b1, 32'h4000_0200}) begin
      errors++; $display("FAIL coinc_redirect: got valid=%b read=%b addr=%h, want 0 1 40000200", if_id_valid, imem_read, imem_address);
    end
    tick();
    checks++;
    if ({if_id_valid, imem_address} !== {1'b0, 32'h4000_0200}) begin
      errors++; $display("FAIL coinc_stale: got valid=%b addr=%h, want 0 40000200", if_id_valid, imem_address);
    end
  endtask

  task automatic test_align_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h4000_0102;
    tick();
    redirect = 1'b0;
    respond(32'hDEAD_BEEF);
    checks++;
    if (imem_address !== 32'h4000_0100) begin
      errors++; $display("FAIL align: got addr=%h, want 40000100", imem_address);
    end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    respond(32'hDEAD_BEEF);
    redirect = 1'b0;
    checks++;
    if (imem_address !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL align_top: got addr=%h, want fffffffc", imem_address);
    end
    respond(32'h0000_006F);
    checks++;
    if ({if_id_valid, if_id_pc, imem_address} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_0000}) begin
      errors++; $display("FAIL wrap: got valid=%b pc=%h addr=%h, want 1 fffffffc 00000000", if_id_valid, if_id_pc, imem_address);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    respond(32'h0000_0013);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_read, if_id_valid, if_id_pc, if_id_instr} !== 66'd0) begin
      errors++; $display("FAIL arst_req: got read=%b valid=%b pc=%h instr=%h, want all 0", imem_read, if_id_valid, if_id_pc, if_id_instr);
    end
    imem_resp = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem_resp = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_read, imem_address, if_id_valid} !== {1'b1, RPC, 1'b0}) begin
      errors++; $display("FAIL arst_restart: got read=%b addr=%h valid=%b, want 1 %h 0", imem_read, imem_address, if_id_valid, RPC);
    end
    respond(32'h0000_0093);
    stall = 1'b1;
    respond(32'h0000_0113);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_read, if_id_valid, if_id_pc} !== 34'd0) begin
      errors++; $display("FAIL arst_hold: got read=%b valid=%b pc=%h, want 0 0 0", imem_read, if_id_valid, if_id_pc);
    end
    stall = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_read, imem_address} !== {1'b1, RPC}) begin
      errors++; $display("FAIL arst_hold_restart: got read=%b addr=%h, want 1 %h", imem_read, imem_address, RPC);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++; $display("FAIL arst_buf_empty: got valid=%b, want 0", if_id_valid);
    end
    respond(32'h0000_0193);
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, RPC, 32'h0000_0193}) begin
      errors++; $display("FAIL arst_first: got valid=%b pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_hold();
    test_redirect_outstanding();
    test_redirect_in_drop();
    test_redirect_coincident();
    test_align_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h4000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port imem_address  output  32  fetch address, word aligned.
REQ-005 SHALL have port imem_read  output  1  fetch request, held until imem_resp.
REQ-006 SHALL have port imem_rdata  input  32  instruction word, valid with imem_resp.
REQ-007 SHALL have port imem_resp  input  1  one-cycle response pulse.
REQ-008 SHALL have port redirect  input  1  taken branch/jal/jalr from execute.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port stall  input  1  decode cannot accept this cycle.
REQ-011 SHALL have port if_id_valid  output  1  decode register holds a live instruction.
REQ-012 SHALL have port if_id_pc  output  32  PC of held instruction.
REQ-013 SHALL have port if_id_instr  output  32  held instruction word.
REQ-014 SHALL have ports if_id_opcode (rv32i_opcode), if_id_funct3 (3), if_id_funct7 (7)  output  decoded from if_id_instr [6:0], [14:12], [31:25], feeding the control decoder directly.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, DROP; reset state FETCH.
REQ-016 SHALL drive imem_read=1 in FETCH and DROP, 0 in HOLD; imem_address = fetch_pc, stable while imem_read=1 and no imem_resp.
REQ-017 SHALL treat output register as accepting when if_id_valid=0 or stall=0.
REQ-018 FETCH, imem_resp=1, redirect=0, accepting: load if_id_pc=fetch_pc, if_id_instr=imem_rdata, if_id_valid=1; fetch_pc += 4; stay FETCH (next request the following cycle).
REQ-019 FETCH, imem_resp=1, redirect=0, not accepting: capture pc/instr in one-entry buffer; fetch_pc += 4; go HOLD.
REQ-020 HOLD, stall=0: move buffer to output register (valid=1); go FETCH.
REQ-021 Consumption without new data (if_id_valid=1, stall=0, nothing loaded) SHALL clear if_id_valid.
REQ-022 redirect SHALL have priority over every other event: clear if_id_valid and buffer, fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-023 redirect in FETCH with imem_resp=0: go DROP; imem_address stays at old fetch_pc until imem_resp.
REQ-024 redirect in FETCH coincident with imem_resp=1: discard imem_rdata; stay FETCH at new target.
REQ-025 DROP, imem_resp=1: discard data, go FETCH; redirect in DROP updates stored target, stays DROP (or FETCH if imem_resp same cycle).
REQ-026 redirect in HOLD: discard buffer; go FETCH.
REQ-027 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 Latency: instruction visible on if_id_* the cycle after its imem_resp; never duplicated, reordered or lost except when flushed by redirect.

Reset
REQ-029 While rst=1: fetch_pc=RESET_PC, state FETCH, imem_read=0, if_id_valid=0, if_id_pc=0, if_id_instr=0 (opcode/funct fields 0), buffer empty; immediate, independent of clk.
REQ-030 First rising edge after rst deasserts SHALL see imem_read=1, imem_address=RESET_PC; reset mid-request abandons it, late imem_resp ignored.

Structure
REQ-031 Fetch FSM state enum SHALL be added to rv32i_types; rv32i_opcode reused from there.
REQ-032 One-entry holding buffer SHALL be sub-module if_skid_buffer (data, load, unload, valid, flush).

Verification
REQ-033 Reset, imem_resp 1 cycle after each request, stall=0 -> addresses 4000_0000, _0004, _0008; if_id_valid pulses each with matching pc/instr.
REQ-034 stall=1 while if_id_valid=1, resp 0x00000013 arrives -> HOLD, imem_read=0; stall drop -> outputs 4000_0004/0x00000013 next cycle, no loss.
REQ-035 redirect to 4000_0100 with request outstanding, resp 3 cycles later -> imem_address held, data discarded, next request 4000_0100, if_id_valid=0 throughout.
REQ-036 redirect coincident with imem_resp -> response dropped, next imem_address = target, no stale instruction emitted.
REQ-037 redirect_pc 4000_0102 -> fetch address 4000_0100; fetch_pc FFFF_FFFC -> next 0000_0000.
REQ-038 rst asserted mid-request and in HOLD -> outputs reset asynchronously; restart at RESET_PC.
